mem_lsu: RTL and testbench

//   Memory-access stage directly downstream of the execute ALU. Takes the ALU result
//   (effective address for LOAD/STORE, result value otherwise) plus rs2 store data.

---
 rtl/mem_lsu_if.sv | 24 ++
 rtl/mem_lsu.sv | 150 +++++++++++++++
 tb/tb_mem_lsu.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-memory request/response bus between the load/store unit (master) and memory (slave).
interface mem_lsu_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = 4
);
   logic                  dmem_req_valid;
   logic                  dmem_req_ready;
   logic [DATA_WIDTH-1:0] dmem_addr;
   logic                  dmem_we;
   logic [STRB_WIDTH-1:0] dmem_wstrb;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  dmem_rsp_valid;
   logic [DATA_WIDTH-1:0] dmem_rsp_rdata;

   modport master (
      output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
      input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
   );

   modport slave (
      input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
      output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
   );
endinterface

// File: rtl/mem_lsu.sv
// Memory-access stage: runs RV32 loads/stores over a valid/ready bus, stalls upstream
// until the access completes, and presents one writeback per instruction.
module mem_lsu #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [6:0]            i_opcode,
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_alu_dout,
   input  logic [DATA_WIDTH-1:0] i_rs2_rd_data,
   output logic                  o_stall,
   mem_lsu_if.master             dmem,
   output logic                  o_misalign,
   output logic                  o_wb_valid,
   output logic [DATA_WIDTH-1:0] o_wb_data
);
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e                state_q;
   logic                  req_valid_q, we_q, misalign_q, wb_valid_q;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, wb_data_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;

   logic                  is_load, is_store, memop, aligned, accept;
   logic [STRB_WIDTH-1:0] st_strb;
   logic [DATA_WIDTH-1:0] st_wdata, rsp_sh, ld_data;

   // Undefined funct3 encodings fall through as ordinary ALU results.
   assign is_load  = (i_opcode == OpLoad) &&
                     (i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
   assign is_store = (i_opcode == OpStore) && (i_funct3 <= 3'd2);
   assign memop    = i_valid && (is_load || is_store);

   always_comb begin
      aligned  = 1'b0;
      st_strb  = '0;
      st_wdata = '0;
      case (i_funct3[1:0])
         2'b00: begin
            aligned  = 1'b1;
            st_strb  = 4'b0001 << i_alu_dout[1:0];
            st_wdata = {4{i_rs2_rd_data[7:0]}};
         end
         2'b01: begin
            aligned  = ~i_alu_dout[0];
            st_strb  = i_alu_dout[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{i_rs2_rd_data[15:0]}};
         end
         2'b10: begin
            aligned  = (i_alu_dout[1:0] == 2'b00);
            st_strb  = 4'hF;
            st_wdata = i_rs2_rd_data;
         end
         default: ;
      endcase
   end

   assign rsp_sh = dmem.dmem_rsp_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_data = rsp_sh;
      case (funct3_q)
         3'd0:    ld_data = {{24{rsp_sh[7]}}, rsp_sh[7:0]};
         3'd1:    ld_data = {{16{rsp_sh[15]}}, rsp_sh[15:0]};
         3'd4:    ld_data = {24'd0, rsp_sh[7:0]};
         3'd5:    ld_data = {16'd0, rsp_sh[15:0]};
         default: ld_data = rsp_sh;
      endcase
   end

   // Gated by reset so the stall is low while reset is held regardless of inputs.
   assign accept  = i_rst_n && (state_q == StIdle) && memop && aligned;
   assign o_stall = accept || (state_q == StReq) || (state_q == StWait);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         req_valid_q <= 1'b0;
         we_q        <= 1'b0;
         misalign_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wb_data_q   <= '0;
         wstrb_q     <= '0;
         funct3_q    <= '0;
         off_q       <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (memop && aligned) begin
                  addr_q      <= {i_alu_dout[DATA_WIDTH-1:2], 2'b00};
                  we_q        <= is_store;
                  wstrb_q     <= is_store ? st_strb : '0;
                  wdata_q     <= is_store ? st_wdata : '0;
                  funct3_q    <= i_funct3;
                  off_q       <= i_alu_dout[1:0];
                  req_valid_q <= 1'b1;
                  state_q     <= StReq;
               end else if (memop) begin
                  misalign_q <= 1'b1;
               end else if (i_valid) begin
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= i_alu_dout;
               end
            end
            StReq: begin
               if (dmem.dmem_req_ready) begin
                  req_valid_q <= 1'b0;
                  if (we_q) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= '0;
                     state_q    <= StDone;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               if (dmem.dmem_rsp_valid) begin
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= ld_data;
                  state_q    <= StDone;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmem.dmem_req_valid = req_valid_q;
   assign dmem.dmem_addr      = addr_q;
   assign dmem.dmem_we        = we_q;
   assign dmem.dmem_wstrb     = wstrb_q;
   assign dmem.dmem_wdata     = wdata_q;
   assign o_misalign          = misalign_q;
   assign o_wb_valid          = wb_valid_q;
   assign o_wb_data           = wb_data_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, store lanes, load extension, misalignment,
// bus back-pressure, and reset in the middle of a load.
module tb_mem_lsu;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_ADD   = 7'h33;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] alu, rs2;
   logic        stall, misalign, wb_valid;
   logic [31:0] wb_data;
   int          nvec = 0;
   int          nerr = 0;

   mem_lsu_if bus ();

   mem_lsu dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (valid),
      .i_opcode      (opcode),
      .i_funct3      (funct3),
      .i_alu_dout    (alu),
      .i_rs2_rd_data (rs2),
      .o_stall       (stall),
      .dmem          (bus.master),
      .o_misalign    (misalign),
      .o_wb_valid    (wb_valid),
      .o_wb_data     (wb_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      valid = 1'b0; opcode = '0; funct3 = '0; alu = '0; rs2 = '0;
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0; bus.dmem_rsp_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall: got %b want 0", stall); end
      nvec++; if (bus.dmem_req_valid !== 1'b0) begin nerr++; $display("FAIL rst_req: got %b want 0", bus.dmem_req_valid); end
      nvec++; if (wb_valid !== 1'b0) begin nerr++; $display("FAIL rst_wbv: got %b want 0", wb_valid); end
      nvec++; if (wb_data !== 32'h0) begin nerr++; $display("FAIL rst_wbd: got %h want 0", wb_data); end
      nvec++; if (misalign !== 1'b0) begin nerr++; $display("FAIL rst_mis: got %b want 0", misalign); end
      nvec++; if (bus.dmem_addr !== 32'h0 || bus.dmem_wstrb !== 4'h0 || bus.dmem_wdata !== 32'h0 ||
                  bus.dmem_we !== 1'b0) begin
         nerr++; $display("FAIL rst_bus: got addr=%h strb=%h wdata=%h we=%b want all 0",
                          bus.dmem_addr, bus.dmem_wstrb, bus.dmem_wdata, bus.dmem_we);
      end
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_passthrough;
      valid = 1'b1; opcode = OP_ADD; funct3 = 3'd0; alu = 32'h0000_1234;
      @(negedge clk);
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL add_stall: got %b want 0", stall); end
      tick;
      valid = 1'b0;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b1) begin nerr++; $display("FAIL add_wbv: got %b want 1", wb_valid); end
      nvec++; if (wb_data !== 32'h0000_1234) begin nerr++; $display("FAIL add_wbd: got %h want 00001234", wb_data); end
      nvec++; if (bus.dmem_req_valid !== 1'b0) begin nerr++; $display("FAIL add_req: got %b want 0", bus.dmem_req_valid); end
      tick;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b0) begin nerr++; $display("FAIL add_wbv_clr: got %b want 0", wb_valid); end
      tick;
   endtask

   task automatic test_back_to_back;
      valid = 1'b1; opcode = OP_ADD; alu = 32'hAAAA_0001;
      tick;
      alu = 32'h5555_0002;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA_0001) begin
         nerr++; $display("FAIL b2b_first: got v=%b d=%h want v=1 d=aaaa0001", wb_valid, wb_data);
      end
      tick;
      valid = 1'b0;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b1 || wb_data !== 32'h5555_0002) begin
         nerr++; $display("FAIL b2b_second: got v=%b d=%h want v=1 d=55550002", wb_valid, wb_data);
      end
      tick;
   endtask

   task automatic test_undef_funct3;
      logic [6:0]  op_t [2];
      logic [31:0] a_t  [2];
      op_t = '{OP_LOAD, OP_STORE};
      a_t  = '{32'h0000_0077, 32'h0000_0099};
      for (int i = 0; i < 2; i++) begin
         valid = 1'b1; opcode = op_t[i]; funct3 = 3'd3; alu = a_t[i];
         @(negedge clk);
         nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL undef_stall[%0d]: got %b want 0", i, stall); end
         tick;
         valid = 1'b0;
         @(negedge clk);
         nvec++; if (wb_valid !== 1'b1 || wb_data !== a_t[i] || bus.dmem_req_valid !== 1'b0) begin
            nerr++; $display("FAIL undef_wb[%0d]: got v=%b d=%h req=%b want v=1 d=%h req=0",
                             i, wb_valid, wb_data, bus.dmem_req_valid, a_t[i]);
         end
         tick;
      end
   endtask

   task automatic test_store;
      logic [2:0]  f3_t  [5];
      logic [31:0] a_t   [5];
      logic [31:0] d_t   [5];
      logic [31:0] ea_t  [5];
      logic [3:0]  es_t  [5];
      logic [31:0] ew_t  [5];
      f3_t = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd1};
      a_t  = '{32'h103, 32'h101, 32'h102, 32'h104, 32'h108};
      d_t  = '{32'hAB, 32'h5A, 32'h1234_ABCD, 32'hCAFE_F00D, 32'h0000_1111};
      ea_t = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h108};
      es_t = '{4'b1000, 4'b0010, 4'b1100, 4'b1111, 4'b0011};
      ew_t = '{32'hABAB_ABAB, 32'h5A5A_5A5A, 32'hABCD_ABCD, 32'hCAFE_F00D, 32'h1111_1111};
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1; opcode = OP_STORE; funct3 = f3_t[i]; alu = a_t[i]; rs2 = d_t[i];
         bus.dmem_req_ready = 1'b1;
         @(negedge clk);
         nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL st_stall_idle[%0d]: got %b want 1", i, stall); end
         tick;
         @(negedge clk);
         nvec++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_we !== 1'b1 || stall !== 1'b1) begin
            nerr++; $display("FAIL st_req[%0d]: got req=%b we=%b stall=%b want 1 1 1",
                             i, bus.dmem_req_valid, bus.dmem_we, stall);
         end
         nvec++; if (bus.dmem_addr !== ea_t[i]) begin nerr++; $display("FAIL st_addr[%0d]: got %h want %h", i, bus.dmem_addr, ea_t[i]); end
         nvec++; if (bus.dmem_wstrb !== es_t[i]) begin nerr++; $display("FAIL st_strb[%0d]: got %b want %b", i, bus.dmem_wstrb, es_t[i]); end
         nvec++; if (bus.dmem_wdata !== ew_t[i]) begin nerr++; $display("FAIL st_wdata[%0d]: got %h want %h", i, bus.dmem_wdata, ew_t[i]); end
         tick;
         @(negedge clk);
         nvec++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || stall !== 1'b0 || bus.dmem_req_valid !== 1'b0) begin
            nerr++; $display("FAIL st_done[%0d]: got v=%b d=%h stall=%b req=%b want 1 0 0 0",
                             i, wb_valid, wb_data, stall, bus.dmem_req_valid);
         end
         tick;
         valid = 1'b0; bus.dmem_req_ready = 1'b0;
         @(negedge clk);
         nvec++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            nerr++; $display("FAIL st_idle[%0d]: got v=%b stall=%b want 0 0", i, wb_valid, stall);
         end
         tick;
      end
   endtask

   task automatic test_load_ext;
      logic [2:0]  f3_t [6];
      logic [31:0] a_t  [6];
      logic [31:0] r_t  [6];
      logic [31:0] e_t  [6];
      logic [31:0] ea;
      f3_t = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2, 3'd0};
      a_t  = '{32'h202, 32'h202, 32'h206, 32'h204, 32'h208, 32'h201};
      r_t  = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h0000_F00F, 32'hDEAD_BEEF, 32'h0000_7F00};
      e_t  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001, 32'hFFFF_F00F, 32'hDEAD_BEEF, 32'h0000_007F};
      for (int i = 0; i < 6; i++) begin
         ea = {a_t[i][31:2], 2'b00};
         valid = 1'b1; opcode = OP_LOAD; funct3 = f3_t[i]; alu = a_t[i];
         bus.dmem_req_ready = 1'b1; bus.dmem_rsp_valid = 1'b0;
         @(negedge clk);
         nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL ld_stall_idle[%0d]: got %b want 1", i, stall); end
         tick;
         @(negedge clk);
         nvec++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_wstrb !== 4'h0 ||
                     bus.dmem_addr !== ea) begin
            nerr++; $display("FAIL ld_req[%0d]: got req=%b we=%b strb=%h addr=%h want 1 0 0 %h",
                             i, bus.dmem_req_valid, bus.dmem_we, bus.dmem_wstrb, bus.dmem_addr, ea);
         end
         tick;
         bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_rdata = r_t[i];
         @(negedge clk);
         nvec++; if (stall !== 1'b1 || bus.dmem_req_valid !== 1'b0) begin
            nerr++; $display("FAIL ld_wait[%0d]: got stall=%b req=%b want 1 0", i, stall, bus.dmem_req_valid);
         end
         tick;
         bus.dmem_rsp_valid = 1'b0;
         @(negedge clk);
         nvec++; if (wb_valid !== 1'b1 || stall !== 1'b0) begin
            nerr++; $display("FAIL ld_done[%0d]: got v=%b stall=%b want 1 0", i, wb_valid, stall);
         end
         nvec++; if (wb_data !== e_t[i]) begin nerr++; $display("FAIL ld_data[%0d]: got %h want %h", i, wb_data, e_t[i]); end
         tick;
         valid = 1'b0;
         @(negedge clk);
         nvec++; if (wb_valid !== 1'b0) begin nerr++; $display("FAIL ld_idle[%0d]: got %b want 0", i, wb_valid); end
         tick;
      end
   endtask

   task automatic test_misalign;
      logic [6:0]  op_t [4];
      logic [2:0]  f3_t [4];
      logic [31:0] a_t  [4];
      op_t = '{OP_LOAD, OP_LOAD, OP_STORE, OP_STORE};
      f3_t = '{3'd2, 3'd1, 3'd2, 3'd1};
      a_t  = '{32'h301, 32'h403, 32'h302, 32'h105};
      bus.dmem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; opcode = op_t[i]; funct3 = f3_t[i]; alu = a_t[i];
         @(negedge clk);
         nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL mis_stall[%0d]: got %b want 0", i, stall); end
         tick;
         valid = 1'b0;
         @(negedge clk);
         nvec++; if (misalign !== 1'b1 || wb_valid !== 1'b0 || bus.dmem_req_valid !== 1'b0) begin
            nerr++; $display("FAIL mis_pulse[%0d]: got mis=%b v=%b req=%b want 1 0 0",
                             i, misalign, wb_valid, bus.dmem_req_valid);
         end
         tick;
         @(negedge clk);
         nvec++; if (misalign !== 1'b0) begin nerr++; $display("FAIL mis_clr[%0d]: got %b want 0", i, misalign); end
         tick;
      end
      bus.dmem_req_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      valid = 1'b1; opcode = OP_LOAD; funct3 = 3'd1; alu = 32'h402;
      bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
      tick;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         nvec++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_addr !== 32'h400 || bus.dmem_wstrb !== 4'h0 ||
                     stall !== 1'b1) begin
            nerr++; $display("FAIL bp_hold[%0d]: got req=%b addr=%h strb=%h stall=%b want 1 400 0 1",
                             c, bus.dmem_req_valid, bus.dmem_addr, bus.dmem_wstrb, stall);
         end
         tick;
      end
      bus.dmem_req_ready = 1'b1;
      tick;
      bus.dmem_req_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         nvec++; if (stall !== 1'b1 || bus.dmem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_wait[%0d]: got stall=%b req=%b v=%b want 1 0 0",
                             c, stall, bus.dmem_req_valid, wb_valid);
         end
         tick;
      end
      bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_rdata = 32'hFF9C_0000;
      tick;
      bus.dmem_rsp_valid = 1'b0;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF9C) begin
         nerr++; $display("FAIL bp_data: got v=%b d=%h want v=1 d=ffffff9c", wb_valid, wb_data);
      end
      tick;
      valid = 1'b0;
      tick;
   endtask

   task automatic test_reset_in_wait;
      valid = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; alu = 32'h500;
      bus.dmem_req_ready = 1'b1;
      tick;
      tick;
      bus.dmem_req_ready = 1'b0;
      @(negedge clk);
      nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL rw_pre_stall: got %b want 1", stall); end
      #2 rst_n = 1'b0;
      #1;
      nvec++; if (stall !== 1'b0 || bus.dmem_req_valid !== 1'b0 || wb_valid !== 1'b0 || bus.dmem_addr !== 32'h0) begin
         nerr++; $display("FAIL rw_rst: got stall=%b req=%b v=%b addr=%h want 0 0 0 0",
                          stall, bus.dmem_req_valid, wb_valid, bus.dmem_addr);
      end
      valid = 1'b0;
      tick;
      rst_n = 1'b1;
      bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_rdata = 32'h1234_5678;
      tick;
      bus.dmem_rsp_valid = 1'b0;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || stall !== 1'b0) begin
         nerr++; $display("FAIL rw_ignore: got v=%b d=%h stall=%b want 0 0 0", wb_valid, wb_data, stall);
      end
      tick;
      // IDLE must still serve a plain op after the abandoned load.
      valid = 1'b1; opcode = OP_ADD; alu = 32'h0000_00C3;
      tick;
      valid = 1'b0;
      @(negedge clk);
      nvec++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_00C3) begin
         nerr++; $display("FAIL rw_after: got v=%b d=%h want v=1 d=000000c3", wb_valid, wb_data);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_passthrough;
      test_back_to_back;
      test_undef_funct3;
      test_store;
      test_load_ext;
      test_misalign;
      test_backpressure;
      test_reset_in_wait;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
